// File: rtl/alu_uart_pkg.sv
// ---------------------------------------------------------------------------
// alu_uart_pkg
// Shared definitions for the UART <-> ALU glue blocks.
//   - word tags carried in the two MSBs of every UART word
//   - default data widths
//   - state encoding of the result transmit FSM
// ---------------------------------------------------------------------------
package alu_uart_pkg;

  localparam int NB_DATA      = 8;
  localparam int NB_OP        = 6;
  localparam int NB_FULL_DATA = 10;

  localparam logic [1:0] TAG_OP1    = 2'b00;
  localparam logic [1:0] TAG_OP2    = 2'b01;
  localparam logic [1:0] TAG_OPCODE = 2'b10;
  localparam logic [1:0] TAG_RESULT = 2'b11;

  typedef enum logic [2:0] {
    TX_IDLE      = 3'd0,
    TX_LOAD      = 3'd1,
    TX_START     = 3'd2,
    TX_WAIT_BUSY = 3'd3,
    TX_WAIT_DONE = 3'd4
  } tx_state_e;

endpackage

// File: rtl/result_fifo.sv
// ---------------------------------------------------------------------------
// result_fifo
// Small synchronous FIFO holding tagged result words until the transmitter
// can take them. Push and pop on the same edge both take effect.
// Ports:
//   i_clk    - clock, rising edge
//   i_reset  - asynchronous, active-low reset
//   i_push   - write i_data this edge (ignored when full without a pop)
//   i_pop    - drop the head entry this edge (ignored when empty)
//   i_data   - word to write
//   o_head   - entry at the read pointer
//   o_count  - number of stored entries (one bit wider than the pointers)
//   o_full   - o_count == DEPTH, registered
//   o_empty  - o_count == 0, registered
// ---------------------------------------------------------------------------
module result_fifo
  import alu_uart_pkg::*;
#(
  parameter int WIDTH  = alu_uart_pkg::NB_FULL_DATA,
  parameter int DEPTH  = 4,
  parameter int NB_PTR = 2
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [WIDTH-1:0]  i_data,
  output logic [WIDTH-1:0]  o_head,
  output logic [NB_PTR:0]   o_count,
  output logic              o_full,
  output logic              o_empty
);

  localparam logic [NB_PTR:0] FULL_COUNT = (NB_PTR + 1)'(DEPTH);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [NB_PTR-1:0] wr_ptr_q, wr_ptr_d;
  logic [NB_PTR-1:0] rd_ptr_q, rd_ptr_d;
  logic [NB_PTR:0]   count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              do_push;
  logic              do_pop;

  // A push into a full FIFO is legal only when the head leaves on the same
  // edge; the new word then lands in the slot being vacated.
  assign do_push = i_push && (!full_q || i_pop);
  assign do_pop  = i_pop && !empty_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
    full_d  = (count_d == FULL_COUNT);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage needs no reset: an entry is only read after it was written.
  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= i_data;
  end

  assign o_head  = mem_q[rd_ptr_q];
  assign o_count = count_q;
  assign o_full  = full_q;
  assign o_empty = empty_q;

endmodule

// File: rtl/alu_result_tx_interface.sv
// ---------------------------------------------------------------------------
// alu_result_tx_interface
// Captures ALU results, buffers them, and feeds them one at a time to the
// UART transmitter as {TAG_RESULT, result} words using a start/busy/done
// handshake. A start that the transmitter never acknowledges is re-issued
// after START_TIMEOUT cycles without popping the FIFO again.
// Ports:
//   i_clk           - clock, rising edge
//   i_reset         - asynchronous, active-low reset
//   i_result        - ALU result
//   i_result_valid  - one-cycle strobe, result is valid
//   i_tx_busy       - transmitter is shifting a frame
//   i_tx_done       - one-cycle strobe at the end of a frame
//   o_tx_data       - word to transmit, held from one load to the next
//   o_tx_start      - one-cycle start request
//   o_fifo_count    - buffered entries
//   o_fifo_full     - buffer is full
//   o_overflow      - sticky, a result was dropped
// ---------------------------------------------------------------------------
module alu_result_tx_interface
  import alu_uart_pkg::*;
#(
  parameter int NB_DATA       = alu_uart_pkg::NB_DATA,
  parameter int NB_FULL_DATA  = alu_uart_pkg::NB_FULL_DATA,
  parameter int FIFO_DEPTH    = 4,
  parameter int NB_PTR        = 2,
  parameter int START_TIMEOUT = 16
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [NB_DATA-1:0]      i_result,
  input  logic                    i_result_valid,
  input  logic                    i_tx_busy,
  input  logic                    i_tx_done,
  output logic [NB_FULL_DATA-1:0] o_tx_data,
  output logic                    o_tx_start,
  output logic [NB_PTR:0]         o_fifo_count,
  output logic                    o_fifo_full,
  output logic                    o_overflow
);

  localparam int NB_TIMER = $clog2(START_TIMEOUT + 1);
  localparam logic [NB_TIMER-1:0] TIMER_LAST = NB_TIMER'(START_TIMEOUT - 1);

  tx_state_e               state_q, state_d;
  logic [NB_FULL_DATA-1:0] tx_data_q, tx_data_d;
  logic                    tx_start_q, tx_start_d;
  logic [NB_TIMER-1:0]     timer_q, timer_d;
  logic                    overflow_q, overflow_d;

  logic [NB_FULL_DATA-1:0] fifo_wr_data;
  logic [NB_FULL_DATA-1:0] fifo_head;
  logic [NB_PTR:0]         fifo_count;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    push;
  logic                    pop;
  logic                    drop;

  // The head is taken on the edge that leaves IDLE, so the word is already
  // on o_tx_data while the FSM sits in LOAD.
  assign pop  = (state_q == TX_IDLE) && !fifo_empty;
  assign push = i_result_valid && (!fifo_full || pop);
  assign drop = i_result_valid && fifo_full && !pop;

  assign fifo_wr_data = {TAG_RESULT, i_result};

  result_fifo #(
    .WIDTH  (NB_FULL_DATA),
    .DEPTH  (FIFO_DEPTH),
    .NB_PTR (NB_PTR)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (push),
    .i_pop   (pop),
    .i_data  (fifo_wr_data),
    .o_head  (fifo_head),
    .o_count (fifo_count),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    timer_d    = timer_q;
    overflow_d = overflow_q | drop;
    case (state_q)
      TX_IDLE: begin
        if (!fifo_empty) begin
          state_d   = TX_LOAD;
          tx_data_d = fifo_head;
        end
      end
      TX_LOAD: begin
        state_d = TX_START;
      end
      TX_START: begin
        state_d = TX_WAIT_BUSY;
        timer_d = '0;
      end
      TX_WAIT_BUSY: begin
        // A done here means the frame was shorter than our reaction time.
        // Retrying only happens with busy low, so start never overlaps busy.
        if (i_tx_done) begin
          state_d = TX_IDLE;
        end else if (i_tx_busy) begin
          state_d = TX_WAIT_DONE;
        end else if (timer_q == TIMER_LAST) begin
          state_d = TX_START;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      TX_WAIT_DONE: begin
        if (i_tx_done || !i_tx_busy) state_d = TX_IDLE;
      end
      default: begin
        state_d = TX_IDLE;
      end
    endcase
    tx_start_d = (state_d == TX_START);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= TX_IDLE;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      timer_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      timer_q    <= timer_d;
      overflow_q <= overflow_d;
    end
  end

  assign o_tx_data    = tx_data_q;
  assign o_tx_start   = tx_start_q;
  assign o_fifo_count = fifo_count;
  assign o_fifo_full  = fifo_full;
  assign o_overflow   = overflow_q;

endmodule

// File: tb/tb_alu_result_tx_interface.sv
// ---------------------------------------------------------------------------
// tb_alu_result_tx_interface
// Drives ALU results into alu_result_tx_interface and plays the UART
// transmitter. Expected words go into a scoreboard queue when a result is
// accepted and are compared against the words the UART model picks up.
// ---------------------------------------------------------------------------
module tb_alu_result_tx_interface;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] result = 8'h00;
  logic       result_valid = 1'b0;
  logic       i_tx_busy;
  logic       i_tx_done;
  logic [9:0] o_tx_data;
  logic       o_tx_start;
  logic [2:0] o_fifo_count;
  logic       o_fifo_full;
  logic       o_overflow;

  int total = 0;
  int bad = 0;

  // UART model controls and observations
  bit         auto_uart = 1'b1;
  int         uart_len = 3;
  int         ignore_req = 0;
  int         ignored_cnt = 0;
  logic [9:0] ignored_word = '0;
  logic       uart_busy = 1'b0;
  logic       uart_done = 1'b0;
  bit         uart_active = 1'b0;
  int         frame_left = 0;
  int         start_seen = 0;
  int         viol = 0;
  logic       man_busy = 1'b0;
  logic       man_done = 1'b0;

  logic [9:0] sb[$];
  logic [9:0] tx_log[$];

  typedef struct {
    logic [7:0] res;
    logic [2:0] exp_count;
    logic       exp_full;
    logic       exp_ovf;
    logic       accept;
  } vec_t;

  vec_t tbl[10];

  assign i_tx_busy = auto_uart ? uart_busy : man_busy;
  assign i_tx_done = auto_uart ? uart_done : man_done;

  alu_result_tx_interface dut (
    .i_clk          (clk),
    .i_reset        (rst_n),
    .i_result       (result),
    .i_result_valid (result_valid),
    .i_tx_busy      (i_tx_busy),
    .i_tx_done      (i_tx_done),
    .o_tx_data      (o_tx_data),
    .o_tx_start     (o_tx_start),
    .o_fifo_count   (o_fifo_count),
    .o_fifo_full    (o_fifo_full),
    .o_overflow     (o_overflow)
  );

  initial forever #5 clk = ~clk;

  // Safety net so the run always ends.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish (got timeout, need finish)");
    $fatal(1, "[TB] watchdog expired");
  end

  // UART transmitter model: on a start it goes busy for uart_len cycles,
  // then drops busy and pulses done. It can be told to ignore starts.
  initial begin
    forever begin
      @(negedge clk);
      if (o_tx_start) start_seen++;
      if (auto_uart) begin
        uart_done = 1'b0;
        if (o_tx_start && uart_busy) viol++;
        if (uart_active) begin
          if (frame_left == 0) begin
            uart_busy   = 1'b0;
            uart_done   = 1'b1;
            uart_active = 1'b0;
          end else begin
            frame_left--;
          end
        end else if (o_tx_start) begin
          if (ignored_cnt < ignore_req) begin
            ignored_cnt++;
            ignored_word = o_tx_data;
          end else begin
            uart_busy   = 1'b1;
            uart_active = 1'b1;
            frame_left  = uart_len;
            tx_log.push_back(o_tx_data);
          end
        end
      end
    end
  end

  // Drive one cycle of input at the falling edge, then sample just after
  // the next rising edge.
  task automatic applyStimulus(input logic v, input logic [7:0] r);
    @(negedge clk);
    result_valid = v;
    result       = r;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Compare every word the UART model has picked up against the scoreboard.
  task automatic drainLog();
    logic [9:0] w;
    while (tx_log.size() > 0) begin
      w = tx_log.pop_front();
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL tx_word: got %0h expected nothing (scoreboard empty)", w);
      end else begin
        checkOutput("tx_word", 32'(w), 32'(sb.pop_front()));
      end
    end
  endtask

  task automatic waitDrain(input int maxc, input string name);
    int  n;
    bit  ok;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < maxc) begin
      @(posedge clk);
      #1;
      drainLog();
      if (sb.size() == 0 && tx_log.size() == 0 && !uart_active && o_fifo_count == 3'd0)
        ok = 1'b1;
      n++;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("[TB] FAIL %s: got not drained after %0d cycles (pending %0d), need drained",
               name, maxc, sb.size());
    end
    repeat (3) @(posedge clk);
    #1;
    drainLog();
  endtask

  task automatic runTable(input int first, input int last, input string name);
    for (int i = first; i <= last; i++) begin
      applyStimulus(1'b1, tbl[i].res);
      if (tbl[i].accept) sb.push_back({2'b11, tbl[i].res});
      checkOutput({name, "_count"}, 32'(o_fifo_count), 32'(tbl[i].exp_count));
      checkOutput({name, "_full"}, 32'(o_fifo_full), 32'(tbl[i].exp_full));
      checkOutput({name, "_ovf"}, 32'(o_overflow), 32'(tbl[i].exp_ovf));
    end
    @(negedge clk);
    result_valid = 1'b0;
  endtask

  // Manual-mode helper: push one word and wait for its start pulse.
  task automatic pushAndWaitStart(input logic [7:0] r, input string name);
    bit got;
    got = 1'b0;
    applyStimulus(1'b1, r);
    for (int i = 0; i < 10 && !got; i++) begin
      applyStimulus(1'b0, 8'h00);
      if (o_tx_start) got = 1'b1;
    end
    checkOutput({name, "_start"}, 32'(got), 32'd1);
  endtask

  initial begin
    int base;
    bit got;

    // rows 0-3: four results into an empty FIFO, one pops on the second edge
    tbl[0] = '{8'h01, 3'd1, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{8'h02, 3'd1, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{8'h03, 3'd2, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{8'h04, 3'd3, 1'b0, 1'b0, 1'b1};
    // rows 4-9: six results against a stalled UART, the last is dropped
    tbl[4] = '{8'h41, 3'd1, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{8'h42, 3'd1, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{8'h43, 3'd2, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{8'h44, 3'd3, 1'b0, 1'b0, 1'b1};
    tbl[8] = '{8'h45, 3'd4, 1'b1, 1'b0, 1'b1};
    tbl[9] = '{8'h46, 3'd4, 1'b1, 1'b1, 1'b0};

    $display("[TB] reset");
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_tx_data", 32'(o_tx_data), 32'h0);
    checkOutput("rst_tx_start", 32'(o_tx_start), 32'h0);
    checkOutput("rst_count", 32'(o_fifo_count), 32'h0);
    checkOutput("rst_full", 32'(o_fifo_full), 32'h0);
    checkOutput("rst_ovf", 32'(o_overflow), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] single word latency");
    uart_len = 3;
    applyStimulus(1'b1, 8'hA5);
    sb.push_back(10'h3A5);
    checkOutput("s1_count_e0", 32'(o_fifo_count), 32'd1);
    applyStimulus(1'b0, 8'h00);
    checkOutput("s1_data_e1", 32'(o_tx_data), 32'h3A5);
    checkOutput("s1_start_e1", 32'(o_tx_start), 32'd0);
    applyStimulus(1'b0, 8'h00);
    checkOutput("s1_start_e2", 32'(o_tx_start), 32'd1);
    applyStimulus(1'b0, 8'h00);
    checkOutput("s1_start_e3", 32'(o_tx_start), 32'd0);
    waitDrain(100, "s1_drain");
    checkOutput("s1_count_end", 32'(o_fifo_count), 32'd0);
    checkOutput("s1_start_end", 32'(o_tx_start), 32'd0);

    $display("[TB] four words, slow UART");
    uart_len = 20;
    runTable(0, 3, "s2");
    waitDrain(300, "s2_drain");
    checkOutput("s2_ovf_end", 32'(o_overflow), 32'd0);

    $display("[TB] start timeout and retry");
    uart_len   = 5;
    ignore_req = ignored_cnt + 1;
    base       = start_seen;
    applyStimulus(1'b1, 8'h5C);
    sb.push_back(10'h35C);
    repeat (3) applyStimulus(1'b0, 8'h00);
    applyStimulus(1'b1, 8'h77);
    sb.push_back(10'h377);
    checkOutput("s5_count_push2", 32'(o_fifo_count), 32'd1);
    @(negedge clk);
    result_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk);
      #1;
      if (start_seen - base >= 2) got = 1'b1;
    end
    checkOutput("s5_restart_seen", 32'(got), 32'd1);
    checkOutput("s5_ignored_word", 32'(ignored_word), 32'h35C);
    checkOutput("s5_count_after_retry", 32'(o_fifo_count), 32'd1);
    waitDrain(200, "s5_drain");
    checkOutput("s5_total_starts", 32'(start_seen - base), 32'd3);
    checkOutput("s5_ovf", 32'(o_overflow), 32'd0);

    $display("[TB] push on the load edge with a full FIFO");
    @(negedge clk);
    auto_uart = 1'b0;
    pushAndWaitStart(8'hA0, "s4");
    man_busy = 1'b1;
    applyStimulus(1'b1, 8'hB1);
    applyStimulus(1'b1, 8'hC2);
    applyStimulus(1'b1, 8'hD3);
    applyStimulus(1'b1, 8'hE4);
    checkOutput("s4_count_full", 32'(o_fifo_count), 32'd4);
    checkOutput("s4_full", 32'(o_fifo_full), 32'd1);
    @(negedge clk);
    result_valid = 1'b0;
    man_busy     = 1'b0;
    man_done     = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("s4_count_idle", 32'(o_fifo_count), 32'd4);
    @(negedge clk);
    man_done     = 1'b0;
    result_valid = 1'b1;
    result       = 8'hF5;
    @(posedge clk);
    #1;
    checkOutput("s4_count_load", 32'(o_fifo_count), 32'd4);
    checkOutput("s4_full_load", 32'(o_fifo_full), 32'd1);
    checkOutput("s4_ovf_load", 32'(o_overflow), 32'd0);
    checkOutput("s4_data_load", 32'(o_tx_data), 32'h3B1);
    @(negedge clk);
    result_valid = 1'b0;
    sb.push_back(10'h3B1);
    sb.push_back(10'h3C2);
    sb.push_back(10'h3D3);
    sb.push_back(10'h3E4);
    sb.push_back(10'h3F5);
    uart_len  = 4;
    auto_uart = 1'b1;
    waitDrain(200, "s4_drain");
    checkOutput("s4_ovf_end", 32'(o_overflow), 32'd0);

    $display("[TB] overflow with stalled UART");
    uart_len = 60;
    runTable(4, 9, "s3");
    checkOutput("s3_full_hold", 32'(o_fifo_full), 32'd1);
    waitDrain(600, "s3_drain");
    checkOutput("s3_ovf_sticky", 32'(o_overflow), 32'd1);

    $display("[TB] reset during frame");
    @(negedge clk);
    auto_uart = 1'b0;
    pushAndWaitStart(8'h11, "s6");
    man_busy = 1'b1;
    applyStimulus(1'b1, 8'h22);
    applyStimulus(1'b1, 8'h33);
    checkOutput("s6_count_queued", 32'(o_fifo_count), 32'd2);
    applyStimulus(1'b0, 8'h00);
    applyStimulus(1'b0, 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("s6_rst_tx_data", 32'(o_tx_data), 32'h0);
    checkOutput("s6_rst_tx_start", 32'(o_tx_start), 32'h0);
    checkOutput("s6_rst_count", 32'(o_fifo_count), 32'h0);
    checkOutput("s6_rst_full", 32'(o_fifo_full), 32'h0);
    checkOutput("s6_rst_ovf", 32'(o_overflow), 32'h0);
    @(negedge clk);
    rst_n    = 1'b1;
    man_busy = 1'b0;
    man_done = 1'b1;
    base     = start_seen;
    @(negedge clk);
    man_done = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    checkOutput("s6_no_start", 32'(start_seen - base), 32'd0);
    checkOutput("s6_count_end", 32'(o_fifo_count), 32'd0);
    checkOutput("s6_tx_data_end", 32'(o_tx_data), 32'h0);

    checkOutput("start_while_busy", 32'(viol), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_result_tx_interface.md
Name: alu_result_tx_interface

Overview:
Downstream neighbour of the UART-to-ALU operand interface. It captures each ALU result when the operand interface flags data ready and buffers it in a small FIFO. Each result is framed as a tagged NB_FULL_DATA-bit word and handed to the UART transmitter through a start/busy/done handshake. It closes the loop UART rx -> operand interface -> ALU -> this block -> UART tx.

Parameters:
NB_DATA, 8, ALU result width
NB_FULL_DATA, 10, UART word width; the 2 tag MSBs plus NB_DATA payload
FIFO_DEPTH, 4, result buffer entries; power of two, at least 2
NB_PTR, 2, log2(FIFO_DEPTH)
START_TIMEOUT, 16, cycles to wait for i_tx_busy after a start pulse before re-issuing it

Ports:
i_clk  in  1  system clock, rising edge
i_reset  in  1  asynchronous, active-low reset; 0 = reset
i_result  in  NB_DATA  ALU result
i_result_valid  in  1  one-cycle pulse, driven by the operand interface o_data_ready
i_tx_busy  in  1  UART tx is shifting a frame
i_tx_done  in  1  one-cycle pulse at the end of a UART tx frame
o_tx_data  out  NB_FULL_DATA  word to transmit: {TAG_RESULT, result}
o_tx_start  out  1  one-cycle start request to the UART tx
o_fifo_count  out  NB_PTR+1  entries currently buffered
o_fifo_full  out  1  o_fifo_count == FIFO_DEPTH
o_overflow  out  1  sticky; a result was dropped

Behaviour:
- Clock and reset: one clock, i_clk. Reset is asynchronous and active-low on i_reset.
- Reset values: o_tx_data=0, o_tx_start=0, o_fifo_count=0, o_fifo_full=0, o_overflow=0, FIFO pointers=0, state=IDLE.
- Reset mid-frame: all outputs and state are cleared immediately. Any later i_tx_done from the frame already in flight is ignored, because the block is in IDLE.
- Push: on the edge where i_result_valid=1 and (not full, or a pop happens on the same edge), {TAG_RESULT, i_result} is written to the FIFO.
- Push while full with no pop on that edge: the result is dropped, o_overflow is set, and count is unchanged. o_overflow is cleared only by reset.
- Push and pop on the same edge: both take effect and count is unchanged. This holds at full and at count=1.
- Pointers wrap modulo FIFO_DEPTH. Count is NB_PTR+1 bits so that full and empty are distinguishable.
- FSM states: IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE.
  - IDLE -> LOAD when o_fifo_count != 0.
  - LOAD: o_tx_data <= FIFO head; pop. Then -> START.
  - START: o_tx_start=1 for exactly this one cycle; timeout counter cleared. Then -> WAIT_BUSY.
  - WAIT_BUSY -> WAIT_DONE when i_tx_busy=1.
  - WAIT_BUSY -> IDLE when i_tx_done=1 (very short frame). This check has priority over the busy check.
  - WAIT_BUSY -> START when START_TIMEOUT cycles pass with neither signal. The word is re-sent unchanged and is not popped again.
  - WAIT_DONE -> IDLE on i_tx_done=1, or on i_tx_busy falling to 0.
- Outputs are registered.
- Latency: for a write accepted at edge E0 into an empty FIFO in IDLE, o_tx_data is valid after E1 and o_tx_start is high between E2 and E3.
- o_tx_data holds its value from LOAD until the next LOAD.
- Back-to-back words: minimum spacing is the UART frame plus 3 cycles (IDLE, LOAD, START).
- The start request is never issued while i_tx_busy=1. START is entered only from LOAD or from timeout, and the timeout path first checks busy=0; otherwise it goes to WAIT_DONE.

Decomposition:
- Shared package (alu_uart_pkg):
  - word tags: TAG_OP1=2'b00, TAG_OP2=2'b01, TAG_OPCODE=2'b10, TAG_RESULT=2'b11
  - NB_DATA, NB_OP, NB_FULL_DATA defaults
  - tx FSM state encoding
- One sub-module: result_fifo, a synchronous FIFO. It takes push/pop/data in and gives head/count/full/empty out, with async active-low reset. Dropping and overflow logic stay in the parent.

Test Plan:
- Reset, then one pulse with i_result=8'hA5 -> o_tx_data=10'h3A5 after 1 cycle, o_tx_start high for 1 cycle 2 cycles after the push; the UART model asserts busy and then done -> state IDLE, count=0.
- Push 8'h01..8'h04 in 4 consecutive cycles while the UART is slow (busy 20 cycles) -> count peaks at 3 or 4; words 0x301, 0x302, 0x303, 0x304 are transmitted in order; o_overflow=0.
- Push 6 results back-to-back while the UART is stalled busy -> o_fifo_full=1; the excess results are dropped; o_overflow=1 and stays 1 until reset; the transmitted words are the first accepted ones, in order.
- i_result_valid asserted on the exact LOAD edge with the FIFO full -> the new entry is accepted; count stays at FIFO_DEPTH; no overflow.
- UART model ignores the start for 16 cycles, then responds -> o_tx_start is re-pulsed once with the same 0x3xx word; the word is transmitted exactly once more; count is not decremented twice.
- Assert i_reset=0 during WAIT_DONE with 2 entries queued -> all outputs are 0 asynchronously; after release and a late i_tx_done pulse, no o_tx_start appears and count=0.
